branch_resolver: RTL and testbench

//  Resolution end of the 2-bit branch predictor. Fetch pushes every predicted branch into an in-order queue.
//  EX resolves branches oldest-first. The block compares actual vs predicted outcome and target.
//  It drives the predictor update port (is_branch/is_taken/b_pc) and, on mispredict, runs a flush/redirect sequence.

---
 rtl/bp_pkg.sv | 24 ++
 rtl/branch_resolver_if.sv | 44 ++++
 rtl/pred_fifo.sv | 72 +++++++
 rtl/branch_resolver.sv | 192 +++++++++++++++++++
 tb/tb_branch_resolver.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/bp_pkg.sv
// Shared types for the branch resolver: counter-state encodings, queued entry, FSM states.
package bp_pkg;

    localparam int unsigned XLEN = 32;

    // 2-bit saturating counter encodings as seen by the predictor
    localparam logic [1:0] ST_T = 2'b11;
    localparam logic [1:0] ST_t = 2'b10;
    localparam logic [1:0] ST_n = 2'b01;
    localparam logic [1:0] ST_N = 2'b00;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic            pred_taken;
        logic [XLEN-1:0] pred_target;
        logic [1:0]      h_state;
    } pred_entry_t;

    typedef enum logic {
        RUN     = 1'b0,
        RECOVER = 1'b1
    } state_e;

endpackage

// File: rtl/branch_resolver_if.sv
// Fetch / EX / predictor-update / redirect signal bundle for the branch resolver.
interface branch_resolver_if;

    logic        f_valid;
    logic        f_ready;
    logic [31:0] f_pc;
    logic        f_pred_taken;
    logic [31:0] f_pred_target;
    logic [1:0]  f_h_state;

    logic        ex_valid;
    logic        ex_taken;
    logic [31:0] ex_target;

    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;

    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    logic [31:0] mispredict_cnt;
    logic [31:0] branch_cnt;

    // Pipeline side: offers branches and resolutions, consumes updates/redirects
    modport master (
        output f_valid, f_pc, f_pred_taken, f_pred_target, f_h_state,
        output ex_valid, ex_taken, ex_target,
        input  f_ready, upd_valid, upd_pc, upd_taken,
        input  flush, redirect_valid, redirect_pc,
        input  mispredict_cnt, branch_cnt
    );

    // Resolver side
    modport slave (
        input  f_valid, f_pc, f_pred_taken, f_pred_target, f_h_state,
        input  ex_valid, ex_taken, ex_target,
        output f_ready, upd_valid, upd_pc, upd_taken,
        output flush, redirect_valid, redirect_pc,
        output mispredict_cnt, branch_cnt
    );

endinterface

// File: rtl/pred_fifo.sv
// Synchronous in-order FIFO holding predicted branches; clear beats push/pop.
// rst is synchronous, active-low.
module pred_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             clear,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data_c,
    output logic             full_c,
    output logic             empty_c,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push_c, do_pop_c;

    assign full_c    = (count_q == CNT_W'(DEPTH));
    assign empty_c   = (count_q == '0);
    assign rd_data_c = mem_q[rd_ptr_q];
    assign count     = count_q;

    // Pointer/occupancy update; pointers wrap naturally since DEPTH is a power of 2
    always_comb begin
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        do_push_c = push && !full_c;
        do_pop_c  = pop && !empty_c;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push_c) begin
                mem_d[wr_ptr_q] = wr_data;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop_c) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(do_push_c) - CNT_W'(do_pop_c);
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/branch_resolver.sv
// Branch resolver: queues predicted branches, checks them against EX outcomes,
// drives predictor updates and a flush/redirect sequence on mispredict.
// rst is synchronous, active-low.
// Optional: define BRANCH_RESOLVER_STATS_EN for saturating branch/mispredict counters.
module branch_resolver
    import bp_pkg::*;
#(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    branch_resolver_if.slave bus
);

    localparam int unsigned CNT_W   = $clog2(DEPTH) + 1;
    localparam int unsigned FC_W    = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam int unsigned ENTRY_W = $bits(pred_entry_t);

    state_e            state_q, state_d;
    logic [FC_W-1:0]   flush_cnt_q, flush_cnt_d;
    logic              f_ready_q, f_ready_d;
    logic              upd_valid_q, upd_valid_d;
    logic [31:0]       upd_pc_q, upd_pc_d;
    logic              upd_taken_q, upd_taken_d;
    logic              flush_q, flush_d;
    logic              redirect_valid_q, redirect_valid_d;
    logic [31:0]       redirect_pc_q, redirect_pc_d;

    logic              push_c, pop_c, clear_c, mispredict_c;
    logic [CNT_W-1:0]  occ_nxt_c;
    pred_entry_t       wr_entry_c, head_c;
    logic [ENTRY_W-1:0] fifo_rd_c;
    logic              fifo_full_c, fifo_empty_c;
    logic [CNT_W-1:0]  fifo_count;

    // Counter state travels with the entry for debug visibility only
    logic              unused_h_state;
    assign unused_h_state = ^head_c.h_state;

    // Pack the incoming fetch branch
    always_comb begin
        wr_entry_c.pc          = bus.f_pc;
        wr_entry_c.pred_taken  = bus.f_pred_taken;
        wr_entry_c.pred_target = bus.f_pred_target;
        wr_entry_c.h_state     = bus.f_h_state;
    end

    assign head_c = pred_entry_t'(fifo_rd_c);

    pred_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_c),
        .pop       (pop_c),
        .clear     (clear_c),
        .wr_data   (wr_entry_c),
        .rd_data_c (fifo_rd_c),
        .full_c    (fifo_full_c),
        .empty_c   (fifo_empty_c),
        .count     (fifo_count)
    );

    // Resolve/recover FSM next-state, compare and output staging
    always_comb begin
        state_d          = state_q;
        flush_cnt_d      = flush_cnt_q;
        pop_c            = 1'b0;
        clear_c          = 1'b0;
        mispredict_c     = 1'b0;
        upd_valid_d      = 1'b0;
        upd_pc_d         = '0;
        upd_taken_d      = 1'b0;
        redirect_valid_d = 1'b0;
        redirect_pc_d    = '0;
        push_c           = bus.f_valid && f_ready_q && !fifo_full_c;

        unique case (state_q)
            RUN: begin
                if (bus.ex_valid && !fifo_empty_c) begin
                    pop_c        = 1'b1;
                    mispredict_c = (bus.ex_taken != head_c.pred_taken) ||
                                   (bus.ex_taken && head_c.pred_taken &&
                                    (bus.ex_target != head_c.pred_target));
                    upd_valid_d  = 1'b1;
                    upd_pc_d     = head_c.pc;
                    upd_taken_d  = bus.ex_taken;
                    if (mispredict_c) begin
                        // Younger queued branches and any same-cycle push are wrong-path
                        clear_c          = 1'b1;
                        redirect_valid_d = 1'b1;
                        redirect_pc_d    = bus.ex_taken ? bus.ex_target
                                                        : head_c.pc + 32'd4;
                        state_d          = RECOVER;
                        flush_cnt_d      = FC_W'(FLUSH_CYCLES - 1);
                    end
                end
            end
            RECOVER: begin
                clear_c = 1'b1;
                if (flush_cnt_q == '0) begin
                    state_d = RUN;
                end else begin
                    flush_cnt_d = flush_cnt_q - FC_W'(1);
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase

        occ_nxt_c = fifo_count + CNT_W'(push_c) - CNT_W'(pop_c);
        flush_d   = (state_d == RECOVER);
        f_ready_d = (state_d == RUN) && (occ_nxt_c != CNT_W'(DEPTH));
    end

    // An EX resolve against an empty queue must never consume an entry
    always_comb begin
        assert (!(pop_c && fifo_empty_c));
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q          <= RUN;
            flush_cnt_q      <= '0;
            f_ready_q        <= 1'b0;
            upd_valid_q      <= 1'b0;
            upd_pc_q         <= '0;
            upd_taken_q      <= 1'b0;
            flush_q          <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
        end else begin
            state_q          <= state_d;
            flush_cnt_q      <= flush_cnt_d;
            f_ready_q        <= f_ready_d;
            upd_valid_q      <= upd_valid_d;
            upd_pc_q         <= upd_pc_d;
            upd_taken_q      <= upd_taken_d;
            flush_q          <= flush_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
        end
    end

    assign bus.f_ready        = f_ready_q;
    assign bus.upd_valid      = upd_valid_q;
    assign bus.upd_pc         = upd_pc_q;
    assign bus.upd_taken      = upd_taken_q;
    assign bus.flush          = flush_q;
    assign bus.redirect_valid = redirect_valid_q;
    assign bus.redirect_pc    = redirect_pc_q;

`ifdef BRANCH_RESOLVER_STATS_EN
    logic [31:0] branch_cnt_q, branch_cnt_d;
    logic [31:0] mispredict_cnt_q, mispredict_cnt_d;

    // Saturating resolve and mispredict counters
    always_comb begin
        branch_cnt_d     = branch_cnt_q;
        mispredict_cnt_d = mispredict_cnt_q;
        if (pop_c && (branch_cnt_q != 32'hFFFF_FFFF)) begin
            branch_cnt_d = branch_cnt_q + 32'd1;
        end
        if (mispredict_c && (mispredict_cnt_q != 32'hFFFF_FFFF)) begin
            mispredict_cnt_d = mispredict_cnt_q + 32'd1;
        end
    end

    // Counter registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            branch_cnt_q     <= '0;
            mispredict_cnt_q <= '0;
        end else begin
            branch_cnt_q     <= branch_cnt_d;
            mispredict_cnt_q <= mispredict_cnt_d;
        end
    end

    assign bus.branch_cnt     = branch_cnt_q;
    assign bus.mispredict_cnt = mispredict_cnt_q;
`else
    assign bus.branch_cnt     = '0;
    assign bus.mispredict_cnt = '0;
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Directed self-checking bench for branch_resolver (DEPTH=4, FLUSH_CYCLES=2).
module tb_branch_resolver;
    import bp_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    branch_resolver_if bus ();

    branch_resolver #(
        .DEPTH        (4),
        .FLUSH_CYCLES (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.f_valid       = 1'b0;
        bus.f_pc          = '0;
        bus.f_pred_taken  = 1'b0;
        bus.f_pred_target = '0;
        bus.f_h_state     = ST_N;
        bus.ex_valid      = 1'b0;
        bus.ex_taken      = 1'b0;
        bus.ex_target     = '0;
    endtask

    task automatic push_entry(input logic [31:0] pc, input logic pt,
                              input logic [31:0] tgt, input logic [1:0] h);
        bus.f_valid       = 1'b1;
        bus.f_pc          = pc;
        bus.f_pred_taken  = pt;
        bus.f_pred_target = tgt;
        bus.f_h_state     = h;
        tick();
        bus.f_valid       = 1'b0;
    endtask

    task automatic resolve(input logic t, input logic [31:0] tgt);
        bus.ex_valid  = 1'b1;
        bus.ex_taken  = t;
        bus.ex_target = tgt;
        tick();
        bus.ex_valid  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle();
        tick();
        tick();
        n_tests++; if (bus.f_ready !== 1'b0) begin n_fail++; $display("FAIL reset_f_ready got %0b want 0", bus.f_ready); end
        n_tests++; if (bus.upd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_upd_valid got %0b want 0", bus.upd_valid); end
        n_tests++; if (bus.upd_pc !== 32'h0) begin n_fail++; $display("FAIL reset_upd_pc got %0h want 0", bus.upd_pc); end
        n_tests++; if (bus.flush !== 1'b0) begin n_fail++; $display("FAIL reset_flush got %0b want 0", bus.flush); end
        n_tests++; if (bus.redirect_valid !== 1'b0) begin n_fail++; $display("FAIL reset_redirect_valid got %0b want 0", bus.redirect_valid); end
        n_tests++; if (bus.redirect_pc !== 32'h0) begin n_fail++; $display("FAIL reset_redirect_pc got %0h want 0", bus.redirect_pc); end
        n_tests++; if (bus.branch_cnt !== 32'h0 || bus.mispredict_cnt !== 32'h0) begin n_fail++; $display("FAIL reset_counters got %0h/%0h want 0/0", bus.branch_cnt, bus.mispredict_cnt); end
        rst = 1'b1;
        tick();
        n_tests++; if (bus.f_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_f_ready got %0b want 1", bus.f_ready); end
    endtask

    task automatic test_correct_taken();
        push_entry(32'h100, 1'b1, 32'h200, ST_T);
        resolve(1'b1, 32'h200);
        n_tests++; if (bus.upd_valid !== 1'b1) begin n_fail++; $display("FAIL t1_upd_valid got %0b want 1", bus.upd_valid); end
        n_tests++; if (bus.upd_pc !== 32'h100) begin n_fail++; $display("FAIL t1_upd_pc got %0h want 100", bus.upd_pc); end
        n_tests++; if (bus.upd_taken !== 1'b1) begin n_fail++; $display("FAIL t1_upd_taken got %0b want 1", bus.upd_taken); end
        n_tests++; if (bus.flush !== 1'b0) begin n_fail++; $display("FAIL t1_flush got %0b want 0", bus.flush); end
        n_tests++; if (bus.redirect_valid !== 1'b0) begin n_fail++; $display("FAIL t1_redirect_valid got %0b want 0", bus.redirect_valid); end
        tick();
        n_tests++; if (bus.upd_valid !== 1'b0) begin n_fail++; $display("FAIL t1_upd_pulse got %0b want 0", bus.upd_valid); end
    endtask

    task automatic test_mispredict_taken();
        push_entry(32'h104, 1'b0, 32'h0, ST_n);
        push_entry(32'h1F0, 1'b0, 32'h0, ST_N);
        // A fetch push in the mispredict cycle must be dropped
        bus.f_valid      = 1'b1;
        bus.f_pc         = 32'hDEAD0;
        bus.f_pred_taken = 1'b0;
        resolve(1'b1, 32'h400);
        bus.f_valid      = 1'b0;
        n_tests++; if (bus.upd_valid !== 1'b1 || bus.upd_pc !== 32'h104) begin n_fail++; $display("FAIL t2_upd got v=%0b pc=%0h want v=1 pc=104", bus.upd_valid, bus.upd_pc); end
        n_tests++; if (bus.upd_taken !== 1'b1) begin n_fail++; $display("FAIL t2_upd_taken got %0b want 1", bus.upd_taken); end
        n_tests++; if (bus.redirect_valid !== 1'b1) begin n_fail++; $display("FAIL t2_redirect_valid got %0b want 1", bus.redirect_valid); end
        n_tests++; if (bus.redirect_pc !== 32'h400) begin n_fail++; $display("FAIL t2_redirect_pc got %0h want 400", bus.redirect_pc); end
        n_tests++; if (bus.flush !== 1'b1 || bus.f_ready !== 1'b0) begin n_fail++; $display("FAIL t2_flush_c1 got flush=%0b rdy=%0b want 1/0", bus.flush, bus.f_ready); end
        tick();
        n_tests++; if (bus.flush !== 1'b1 || bus.f_ready !== 1'b0) begin n_fail++; $display("FAIL t2_flush_c2 got flush=%0b rdy=%0b want 1/0", bus.flush, bus.f_ready); end
        n_tests++; if (bus.redirect_valid !== 1'b0 || bus.upd_valid !== 1'b0) begin n_fail++; $display("FAIL t2_strobes got rv=%0b uv=%0b want 0/0", bus.redirect_valid, bus.upd_valid); end
        tick();
        n_tests++; if (bus.flush !== 1'b0 || bus.f_ready !== 1'b1) begin n_fail++; $display("FAIL t2_flush_end got flush=%0b rdy=%0b want 0/1", bus.flush, bus.f_ready); end
        resolve(1'b1, 32'h123);
        n_tests++; if (bus.upd_valid !== 1'b0 || bus.redirect_valid !== 1'b0) begin n_fail++; $display("FAIL t2_queue_empty got uv=%0b rv=%0b want 0/0", bus.upd_valid, bus.redirect_valid); end
    endtask

    task automatic test_mispredict_not_taken();
        push_entry(32'h108, 1'b1, 32'h300, ST_t);
        resolve(1'b0, 32'h0);
        n_tests++; if (bus.upd_pc !== 32'h108 || bus.upd_taken !== 1'b0) begin n_fail++; $display("FAIL t3_upd got pc=%0h t=%0b want 108/0", bus.upd_pc, bus.upd_taken); end
        n_tests++; if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'h10C) begin n_fail++; $display("FAIL t3_redirect got v=%0b pc=%0h want 1/10c", bus.redirect_valid, bus.redirect_pc); end
        tick();
        tick();
        n_tests++; if (bus.f_ready !== 1'b1) begin n_fail++; $display("FAIL t3_recovered got %0b want 1", bus.f_ready); end
        // Both taken but target differs
        push_entry(32'h110, 1'b1, 32'h500, ST_T);
        resolve(1'b1, 32'h600);
        n_tests++; if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'h600) begin n_fail++; $display("FAIL t3_target_miss got v=%0b pc=%0h want 1/600", bus.redirect_valid, bus.redirect_pc); end
        tick();
        tick();
        // Correct not-taken: target input is irrelevant
        push_entry(32'h114, 1'b0, 32'h0, ST_N);
        resolve(1'b0, 32'h999);
        n_tests++; if (bus.upd_valid !== 1'b1 || bus.redirect_valid !== 1'b0 || bus.flush !== 1'b0) begin n_fail++; $display("FAIL t3_nt_ok got uv=%0b rv=%0b fl=%0b want 1/0/0", bus.upd_valid, bus.redirect_valid, bus.flush); end
    endtask

    task automatic test_pc_wrap();
        push_entry(32'hFFFF_FFFC, 1'b1, 32'h80, ST_T);
        resolve(1'b0, 32'h0);
        n_tests++; if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'h0) begin n_fail++; $display("FAIL t4_wrap got v=%0b pc=%0h want 1/0", bus.redirect_valid, bus.redirect_pc); end
        tick();
        tick();
        n_tests++; if (bus.f_ready !== 1'b1) begin n_fail++; $display("FAIL t4_recovered got %0b want 1", bus.f_ready); end
    endtask

    task automatic test_full_and_back_to_back();
        logic [31:0] exp_pc [4];
        exp_pc = '{32'h208, 32'h20C, 32'h210, 32'h214};
        push_entry(32'h200, 1'b0, 32'h0, ST_N);
        push_entry(32'h204, 1'b0, 32'h0, ST_N);
        push_entry(32'h208, 1'b0, 32'h0, ST_N);
        n_tests++; if (bus.f_ready !== 1'b1) begin n_fail++; $display("FAIL t5_ready_at3 got %0b want 1", bus.f_ready); end
        push_entry(32'h20C, 1'b0, 32'h0, ST_N);
        n_tests++; if (bus.f_ready !== 1'b0) begin n_fail++; $display("FAIL t5_full got %0b want 0", bus.f_ready); end
        push_entry(32'h999, 1'b0, 32'h0, ST_N);
        n_tests++; if (bus.f_ready !== 1'b0) begin n_fail++; $display("FAIL t5_still_full got %0b want 0", bus.f_ready); end
        resolve(1'b0, 32'h0);
        n_tests++; if (bus.upd_pc !== 32'h200 || bus.f_ready !== 1'b1) begin n_fail++; $display("FAIL t5_pop1 got pc=%0h rdy=%0b want 200/1", bus.upd_pc, bus.f_ready); end
        // Simultaneous push and pop keeps occupancy at 3
        bus.f_valid      = 1'b1;
        bus.f_pc         = 32'h210;
        bus.f_pred_taken = 1'b0;
        resolve(1'b0, 32'h0);
        bus.f_valid      = 1'b0;
        n_tests++; if (bus.upd_valid !== 1'b1 || bus.upd_pc !== 32'h204 || bus.f_ready !== 1'b1) begin n_fail++; $display("FAIL t5_push_pop got v=%0b pc=%0h rdy=%0b want 1/204/1", bus.upd_valid, bus.upd_pc, bus.f_ready); end
        push_entry(32'h214, 1'b0, 32'h0, ST_N);
        n_tests++; if (bus.f_ready !== 1'b0) begin n_fail++; $display("FAIL t5_refull got %0b want 0", bus.f_ready); end
        for (int i = 0; i < 4; i++) begin
            resolve(1'b0, 32'h0);
            n_tests++; if (bus.upd_valid !== 1'b1 || bus.upd_pc !== exp_pc[i] || bus.redirect_valid !== 1'b0) begin n_fail++; $display("FAIL t5_order%0d got v=%0b pc=%0h rv=%0b want 1/%0h/0", i, bus.upd_valid, bus.upd_pc, bus.redirect_valid, exp_pc[i]); end
        end
        resolve(1'b1, 32'h123);
        n_tests++; if (bus.upd_valid !== 1'b0 || bus.redirect_valid !== 1'b0 || bus.flush !== 1'b0) begin n_fail++; $display("FAIL t5_empty_ex got uv=%0b rv=%0b fl=%0b want 0/0/0", bus.upd_valid, bus.redirect_valid, bus.flush); end
    endtask

    task automatic test_reset_in_recover();
        push_entry(32'h300, 1'b0, 32'h0, ST_N);
        resolve(1'b1, 32'h700);
        n_tests++; if (bus.flush !== 1'b1) begin n_fail++; $display("FAIL t6_in_recover got %0b want 1", bus.flush); end
        rst = 1'b0;
        tick();
        n_tests++; if (bus.flush !== 1'b0 || bus.f_ready !== 1'b0) begin n_fail++; $display("FAIL t6_reset got flush=%0b rdy=%0b want 0/0", bus.flush, bus.f_ready); end
        n_tests++; if (bus.upd_valid !== 1'b0 || bus.redirect_valid !== 1'b0) begin n_fail++; $display("FAIL t6_reset_strobes got uv=%0b rv=%0b want 0/0", bus.upd_valid, bus.redirect_valid); end
        n_tests++; if (bus.branch_cnt !== 32'h0 || bus.mispredict_cnt !== 32'h0) begin n_fail++; $display("FAIL t6_reset_counters got %0h/%0h want 0/0", bus.branch_cnt, bus.mispredict_cnt); end
        rst = 1'b1;
        tick();
        n_tests++; if (bus.f_ready !== 1'b1 || bus.flush !== 1'b0) begin n_fail++; $display("FAIL t6_run got rdy=%0b flush=%0b want 1/0", bus.f_ready, bus.flush); end
        resolve(1'b0, 32'h0);
        n_tests++; if (bus.upd_valid !== 1'b0) begin n_fail++; $display("FAIL t6_queue_empty got %0b want 0", bus.upd_valid); end
    endtask

    task automatic test_stats();
        logic [31:0] exp_br, exp_mp;
`ifdef BRANCH_RESOLVER_STATS_EN
        exp_br = 32'd3;
        exp_mp = 32'd1;
`else
        exp_br = 32'd0;
        exp_mp = 32'd0;
`endif
        push_entry(32'h400, 1'b0, 32'h0, ST_N);
        resolve(1'b0, 32'h0);
        push_entry(32'h404, 1'b1, 32'h800, ST_T);
        resolve(1'b1, 32'h800);
        push_entry(32'h408, 1'b0, 32'h0, ST_n);
        resolve(1'b1, 32'h900);
        tick();
        tick();
        n_tests++; if (bus.branch_cnt !== exp_br) begin n_fail++; $display("FAIL stats_branch got %0d want %0d", bus.branch_cnt, exp_br); end
        n_tests++; if (bus.mispredict_cnt !== exp_mp) begin n_fail++; $display("FAIL stats_mispredict got %0d want %0d", bus.mispredict_cnt, exp_mp); end
        n_tests++; if (bus.f_ready !== 1'b1) begin n_fail++; $display("FAIL stats_recovered got %0b want 1", bus.f_ready); end
    endtask

    initial begin
        test_reset();
        test_correct_taken();
        test_mispredict_taken();
        test_mispredict_not_taken();
        test_pc_wrap();
        test_full_and_back_to_back();
        test_reset_in_recover();
        test_stats();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired before end of sequence");
        $fatal(1, "watchdog");
    end

endmodule
